// File: rtl/instr_fetch_stage.sv
// ----------------------------------------------------------------------------
// instr_fetch_stage
//   Instruction fetch stage feeding the main decoder. Holds the PC, runs a
//   req/ack handshake with instruction memory, latches one instruction into a
//   single-entry IR and offers it to decode with a valid/ready handshake.
//   Downstream redirects (taken beq, j) discard the current path.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   imem_req/imem_addr       fetch request and word-aligned address (out)
//   imem_ack/imem_rdata      fetch completion and instruction word (in)
//   if_valid/id_ready        IR -> decode handshake
//   instr/op/pc_plus4        IR contents, opcode field, IR address + 4
//   redirect/redirect_pc     flush current path and fetch from redirect_pc
//   dbg_state                current FSM state, for observation only
//
// Handshake semantics (both interfaces):
//   A transfer happens exactly on a rising edge where the producer's valid
//   (imem_req for memory requests completing with imem_ack; if_valid towards
//   decode) and the consumer's acceptance (imem_ack; id_ready) are both high.
//   While valid is high and not yet accepted, the producer holds its payload
//   (imem_addr; instr and pc_plus4) stable and does not withdraw valid,
//   except that a redirect withdraws if_valid in the same cycle.
// ----------------------------------------------------------------------------
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [31:0] pc_plus4,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] ir_q, ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;

    logic [31:0] redirect_aligned;
    logic [31:0] seq_pc;
    logic        start_fetch;

    // Low address bits of a redirect target are dropped, never trusted.
    assign redirect_aligned = redirect_pc & ~32'h3;
    // Wraps modulo 2^32 by width truncation.
    assign seq_pc = req_addr_q + 32'd4;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        ir_d        = ir_q;
        ir_valid_d  = ir_valid_q;
        pc_plus4_d  = pc_plus4_q;
        start_fetch = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (redirect) pc_d = redirect_aligned;
                state_d     = S_FETCH;
                start_fetch = 1'b1;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    if (redirect) begin
                        // Wrong-path data: drop it and issue the new request.
                        pc_d        = redirect_aligned;
                        start_fetch = 1'b1;
                    end else begin
                        ir_d       = imem_rdata;
                        ir_valid_d = 1'b1;
                        pc_plus4_d = seq_pc;
                        pc_d       = seq_pc;
                        state_d    = S_HOLD;
                    end
                end else if (redirect) begin
                    // Request is already outstanding; it must complete
                    // before the new path can be requested.
                    pc_d    = redirect_aligned;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (redirect) pc_d = redirect_aligned;
                if (imem_ack) begin
                    state_d     = S_FETCH;
                    start_fetch = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    ir_valid_d  = 1'b0;
                    pc_d        = redirect_aligned;
                    state_d     = S_FETCH;
                    start_fetch = 1'b1;
                end else if (if_valid && id_ready) begin
                    ir_valid_d  = 1'b0;
                    state_d     = S_FETCH;
                    start_fetch = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The request address is captured only when a new request starts,
        // so imem_addr cannot move while imem_req is high.
        if (start_fetch) req_addr_d = pc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC_ALIGNED;
            req_addr_q <= RESET_PC_ALIGNED;
            ir_q       <= NOP_INSTR;
            ir_valid_q <= 1'b0;
            pc_plus4_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign imem_req  = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign imem_addr = req_addr_q;
    assign if_valid  = ir_valid_q & ~redirect;
    assign instr     = if_valid ? ir_q : NOP_INSTR;
    assign op        = instr[31:26];
    assign pc_plus4  = pc_plus4_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
module tb_instr_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] held_instr;

    instr_fetch_stage #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .id_ready   (id_ready),
        .instr      (instr),
        .op         (op),
        .pc_plus4   (pc_plus4),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        else
            n_pass++;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    // Present an ack for one cycle; a non-dropped word is queued as expected.
    task automatic drive_ack(input logic [31:0] data, input bit expect_keep);
        imem_ack   = 1'b1;
        imem_rdata = data;
        if (expect_keep) exp_q.push_back(data);
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        settle();
    endtask

    // Called while id_ready=1 and if_valid is expected high before the edge.
    task automatic expect_transfer(input string tag);
        logic [31:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        check_eq({tag, "_valid"}, {31'b0, if_valid}, 32'd1);
        check_eq({tag, "_instr"}, instr, e);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        id_ready    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // Reset state
        step(); settle();
        check_eq("rst_req",   {31'b0, imem_req}, 32'd0);
        check_eq("rst_addr",  imem_addr, RST_PC);
        check_eq("rst_valid", {31'b0, if_valid}, 32'd0);
        check_eq("rst_instr", instr, NOP);
        check_eq("rst_pc4",   pc_plus4, 32'h0);
        check_eq("rst_state", {30'b0, dbg_state}, 32'd0);

        // 1. First fetch after reset release
        rst_n = 1'b1;
        settle();
        check_eq("t1_c1_req", {31'b0, imem_req}, 32'd0);
        step(); settle();
        check_eq("t1_c2_req",  {31'b0, imem_req}, 32'd1);
        check_eq("t1_c2_addr", imem_addr, RST_PC);
        check_eq("t1_c2_valid", {31'b0, if_valid}, 32'd0);
        drive_ack(32'h8C08_0004, 1'b1);
        check_eq("t1_valid", {31'b0, if_valid}, 32'd1);
        check_eq("t1_op",    {26'b0, op}, 32'h23);
        check_eq("t1_pc4",   pc_plus4, 32'h0040_0004);
        check_eq("t1_req",   {31'b0, imem_req}, 32'd0);

        // 2. Back-pressure for three cycles, then transfer
        held_instr = 32'h8C08_0004;
        for (int i = 0; i < 3; i++) begin
            step(); settle();
            check_eq("t2_hold_instr", instr, held_instr);
            check_eq("t2_hold_req",   {31'b0, imem_req}, 32'd0);
            check_eq("t2_hold_pc4",   pc_plus4, 32'h0040_0004);
        end
        step();
        id_ready = 1'b1;
        settle();
        expect_transfer("t2_xfer");
        step();
        id_ready = 1'b0;
        settle();
        check_eq("t2_next_req",   {31'b0, imem_req}, 32'd1);
        check_eq("t2_next_addr",  imem_addr, 32'h0040_0004);
        check_eq("t2_next_valid", {31'b0, if_valid}, 32'd0);

        // 3. Redirect while the fetch at 0x0040_0004 is outstanding
        redirect    = 1'b1;
        redirect_pc = 32'h0040_0103;
        step();
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        settle();
        check_eq("t3_drain_state", {30'b0, dbg_state}, 32'd2);
        for (int i = 0; i < 2; i++) begin
            check_eq("t3_drain_req",  {31'b0, imem_req}, 32'd1);
            check_eq("t3_drain_addr", imem_addr, 32'h0040_0004);
            step(); settle();
        end
        check_eq("t3_drain_addr3", imem_addr, 32'h0040_0004);
        drive_ack(32'hDEAD_BEEF, 1'b0);
        check_eq("t3_drop_valid", {31'b0, if_valid}, 32'd0);
        check_eq("t3_new_req",    {31'b0, imem_req}, 32'd1);
        check_eq("t3_new_addr",   imem_addr, 32'h0040_0100);
        drive_ack(32'h2009_0005, 1'b1);
        check_eq("t3_valid", {31'b0, if_valid}, 32'd1);
        check_eq("t3_op",    {26'b0, op}, 32'h08);
        check_eq("t3_pc4",   pc_plus4, 32'h0040_0104);

        // 4. Redirect kills a same-cycle transfer
        step();
        id_ready    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        settle();
        check_eq("t4_kill_valid", {31'b0, if_valid}, 32'd0);
        check_eq("t4_kill_instr", instr, NOP);
        check_eq("t4_kill_op",    {26'b0, op}, 32'h0);
        exp_q.delete();
        step();
        id_ready    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        settle();
        check_eq("t4_req",   {31'b0, imem_req}, 32'd1);
        check_eq("t4_addr",  imem_addr, 32'hFFFF_FFFC);
        check_eq("t4_valid", {31'b0, if_valid}, 32'd0);

        // 5. PC wrap at the top of the address space
        drive_ack(32'h0810_0000, 1'b1);
        check_eq("t5_pc4", pc_plus4, 32'h0000_0000);
        check_eq("t5_op",  {26'b0, op}, 32'h02);
        step();
        id_ready = 1'b1;
        settle();
        expect_transfer("t5_xfer");
        step();
        id_ready = 1'b0;
        settle();
        check_eq("t5_next_addr", imem_addr, 32'h0000_0000);
        check_eq("t5_next_req",  {31'b0, imem_req}, 32'd1);

        // 6. Reset asserted mid-request; a late ack after release is ignored
        step();
        rst_n = 1'b0;
        settle();
        check_eq("t6_rst_req",   {31'b0, imem_req}, 32'd0);
        check_eq("t6_rst_valid", {31'b0, if_valid}, 32'd0);
        check_eq("t6_rst_instr", instr, NOP);
        check_eq("t6_rst_addr",  imem_addr, RST_PC);
        step();
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        settle();
        check_eq("t6_fetch_req",   {31'b0, imem_req}, 32'd1);
        check_eq("t6_fetch_addr",  imem_addr, RST_PC);
        check_eq("t6_fetch_valid", {31'b0, if_valid}, 32'd0);
        step(); settle();
        check_eq("t6_still_req",   {31'b0, imem_req}, 32'd1);
        check_eq("t6_still_valid", {31'b0, if_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
